// File: rtl/adder_pkg.sv
// ============================================================================
// Module : adder_pkg
// Brief  : Shared width, operand type and registered-result type for the adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pkg;

   localparam int ADDER_WIDTH = 8;

   typedef logic [ADDER_WIDTH-1:0] operand_t;

   typedef struct packed {
      operand_t sum;
      logic     c_out;
      logic     overflow;
   } result_t;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder
// Brief  : Single-bit full-adder cell, one link of the ripple-carry chain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

`default_nettype wire

// File: rtl/binary_adder_8bit.sv
// ============================================================================
// Module : binary_adder_8bit
// Brief  : Ripple-carry adder with live combinational outputs and a
//          one-cycle registered copy qualified by out_valid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module binary_adder_8bit
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             C_out,
   output logic             overflow,
   output logic [WIDTH-1:0] sum_q,
   output logic             C_out_q,
   output logic             overflow_q,
   output logic             out_valid
);

   // Same layout as adder_pkg::result_t, but sized by this instance's WIDTH.
   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             c_out;
      logic             overflow;
   } result_w_t;

   logic [WIDTH:0] carry;
   result_w_t      res_d;
   result_w_t      res_q;
   logic           valid_q;

   assign carry[0] = C_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

   assign C_out    = carry[WIDTH];
   assign overflow = carry[WIDTH-1] ^ carry[WIDTH];

   assign res_d.sum      = sum;
   assign res_d.c_out    = C_out;
   assign res_d.overflow = overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            res_q <= res_d;
         end
      end
   end

   assign sum_q      = res_q.sum;
   assign C_out_q    = res_q.c_out;
   assign overflow_q = res_q.overflow;
   assign out_valid  = valid_q;

endmodule : binary_adder_8bit

`default_nettype wire

// File: tb/tb_binary_adder_8bit.sv
// ============================================================================
// Module : tb_binary_adder_8bit
// Brief  : Self-checking bench for binary_adder_8bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_binary_adder_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic       C_in;
   logic       in_valid;
   logic [7:0] sum;
   logic       C_out;
   logic       overflow;
   logic [7:0] sum_q;
   logic       C_out_q;
   logic       overflow_q;
   logic       out_valid;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       ov;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   binary_adder_8bit dut (
      .clk        (clk),
      .rst        (rst),
      .A          (A),
      .B          (B),
      .C_in       (C_in),
      .in_valid   (in_valid),
      .sum        (sum),
      .C_out      (C_out),
      .overflow   (overflow),
      .sum_q      (sum_q),
      .C_out_q    (C_out_q),
      .overflow_q (overflow_q),
      .out_valid  (out_valid)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
   endfunction

   // Drive on the falling edge, check the combinational path, queue the registered expectation.
   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic v, input logic r,
                        input logic [7:0] es, input logic eco, input logic eov);
      exp_t e;
      @(negedge clk);
      A = a; B = b; C_in = c; in_valid = v; rst = r;
      #1;
      chk("sum", sum, es);
      chk("C_out", C_out, eco);
      chk("overflow", overflow, eov);
      if (v && !r) begin
         e.s = es; e.co = eco; e.ov = eov;
         q.push_back(e);
      end
   endtask

   // Monitor: registered outputs one cycle after each sampled edge.
   initial begin : monitor
      logic       ev, er;
      logic [7:0] hs;
      logic       hco, hov;
      exp_t       e;
      hs = '0; hco = 1'b0; hov = 1'b0;
      forever begin
         @(posedge clk);
         ev = in_valid && !rst;
         er = rst;
         #1;
         chk("out_valid", out_valid, ev);
         if (er) begin
            hs = '0; hco = 1'b0; hov = 1'b0;
         end else if (ev) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL scoreboard: out_valid with no expected result queued (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               hs = e.s; hco = e.co; hov = e.ov;
            end
         end
         chk("sum_q", sum_q, hs);
         chk("C_out_q", C_out_q, hco);
         chk("overflow_q", overflow_q, hov);
      end
   end

   initial begin : stimulus
      logic [8:0] full;
      logic [7:0] ra, rb;
      logic       rc, rv, rov;
      rst = 1'b1; A = '0; B = '0; C_in = 1'b0; in_valid = 1'b0;

      drive(8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 1'b0);
      drive(8'd10,  8'd20,  1'b0, 1'b1, 1'b1, 8'd30,  1'b0, 1'b0);
      drive(8'd10,  8'd20,  1'b0, 1'b1, 1'b1, 8'd30,  1'b0, 1'b0);
      drive(8'd10,  8'd20,  1'b0, 1'b1, 1'b0, 8'd30,  1'b0, 1'b0);
      drive(8'd10,  8'd20,  1'b0, 1'b0, 1'b0, 8'd30,  1'b0, 1'b0);
      drive(8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
      drive(8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
      drive(8'd255, 8'd0,   1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0);
      drive(8'd200, 8'd100, 1'b0, 1'b1, 1'b0, 8'd44,  1'b1, 1'b0);
      drive(8'd127, 8'd1,   1'b0, 1'b1, 1'b0, 8'd128, 1'b0, 1'b1);
      drive(8'd128, 8'd128, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b1);
      drive(8'd1,   8'd2,   1'b0, 1'b1, 1'b0, 8'd3,   1'b0, 1'b0);
      drive(8'd3,   8'd4,   1'b1, 1'b1, 1'b0, 8'd8,   1'b0, 1'b0);
      drive(8'd250, 8'd10,  1'b0, 1'b1, 1'b0, 8'd4,   1'b1, 1'b0);
      drive(8'd5,   8'd5,   1'b0, 1'b0, 1'b0, 8'd10,  1'b0, 1'b0);
      drive(8'd7,   8'd8,   1'b0, 1'b1, 1'b0, 8'd15,  1'b0, 1'b0);
      drive(8'd9,   8'd9,   1'b0, 1'b1, 1'b1, 8'd18,  1'b0, 1'b0);
      drive(8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom);
         rv   = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         rov  = (ra[7] == rb[7]) && (full[7] != ra[7]);
         drive(ra, rb, rc, rv, 1'b0, full[7:0], full[8], rov);
      end

      drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_binary_adder_8bit

`default_nettype wire
